// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head entry is always presented on out_data and qualified by out_valid.
// All outputs are decoded from registered state only.
//
// Handshake: a read is accepted when in_read is high and the FIFO is
// non-empty. A write is accepted when in_write is high and either there is
// room, or a read is accepted in the same cycle. A rejected write is dropped
// and leaves no trace. A rejected read is ignored. Both acceptances take
// effect at the rising clock edge.
module sync_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_write,
  input  logic [DATA_BITS-1:0]    in_data,
  input  logic                    in_read,
  output logic [DATA_BITS-1:0]    out_data,
  output logic                    out_valid,
  output logic                    out_full,
  output logic [ADDRESS_BITS:0]   out_count
);

  localparam int                DEPTH   = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS:0] DEPTH_C = (ADDRESS_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0]    mem_q [DEPTH];
  logic [ADDRESS_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_BITS:0]   count_q,  count_d;

  logic rd_accept;
  logic wr_accept;

  // Acceptance decode. A full FIFO can still take a write when a pop frees
  // the slot in the same edge. An empty FIFO never pops, so no same-cycle
  // bypass exists.
  always_comb begin
    rd_accept = in_read && (count_q != '0);
    wr_accept = in_write && ((count_q != DEPTH_C) || rd_accept);
  end

  // Next-state for the pointers and the occupancy counter. The pointers wrap
  // naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDRESS_BITS'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + ADDRESS_BITS'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADDRESS_BITS + 1)'(1);
      2'b01:   count_d = count_q - (ADDRESS_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register. Reset discards the contents logically by clearing the
  // pointers and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write. The array is never cleared, and reset blocks a concurrent write.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem_q[wr_ptr_q] <= in_data;
  end

  // Output decode from registered state. out_data is forced to zero when the FIFO is empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_full  = (count_q == DEPTH_C);
    out_count = count_q;
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scenarios plus random traffic for sync_fifo,
// checked against a queue-based behavioural model.
module tb_sync_fifo;

  localparam int DATA_BITS    = 8;
  localparam int ADDRESS_BITS = 4;
  localparam int DEPTH        = 1 << ADDRESS_BITS;

  logic                  clk;
  logic                  reset;
  logic                  in_write;
  logic [DATA_BITS-1:0]  in_data;
  logic                  in_read;
  logic [DATA_BITS-1:0]  out_data;
  logic                  out_valid;
  logic                  out_full;
  logic [ADDRESS_BITS:0] out_count;

  logic [DATA_BITS-1:0] exp_q[$];
  int n_compared;
  int n_mismatched;
  int peak;

  sync_fifo #(.DATA_BITS(DATA_BITS), .ADDRESS_BITS(ADDRESS_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_write  (in_write),
    .in_data   (in_data),
    .in_read   (in_read),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_full  (out_full),
    .out_count (out_count)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compares every output against the queue model.
  task automatic check_model();
    int sz;
    logic [31:0] head;
    sz   = exp_q.size();
    head = (sz != 0) ? 32'(exp_q[0]) : 32'd0;
    check("count", 32'(out_count), 32'(sz));
    check("valid", 32'(out_valid), 32'(sz != 0));
    check("full",  32'(out_full),  32'(sz == DEPTH));
    check("data",  32'(out_data),  head);
    if (32'(out_count) > peak) peak = int'(out_count);
  endtask

  // Driver: applies one cycle of inputs, advances the model, then checks.
  task automatic step(input logic w, input logic [DATA_BITS-1:0] d, input logic r, input logic rst);
    bit rd_ok;
    bit wr_ok;
    rd_ok = r && (exp_q.size() != 0);
    wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
    in_write = w;
    in_data  = d;
    in_read  = r;
    reset    = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rd_ok) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(d);
    end
    in_write = 1'b0;
    in_read  = 1'b0;
    reset    = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    peak         = 0;
    reset    = 1'b1;
    in_write = 1'b0;
    in_read  = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);

    // 1: four writes, then four reads in order.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(i * 3), 1'b0, 1'b0);
      if (i == 0) begin
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_data",  32'(out_data),  32'd0);
      end
    end
    check("t1_count", 32'(out_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_read", 32'(out_data), 32'(i * 3));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("t1_end_valid", 32'(out_valid), 32'd0);
    check("t1_end_data",  32'(out_data),  32'd0);

    // 2: fill to full, drop an overflow write, then drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("t2_full", 32'(out_full), 32'(i == DEPTH - 1));
    end
    step(1'b1, 8'd31, 1'b0, 1'b0);
    check("t2_drop_count", 32'(out_count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain", 32'(out_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("t2_empty", 32'(out_valid), 32'd0);

    // 3: read and write together while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'd20, 1'b1, 1'b0);
    check("t3_count", 32'(out_count), 32'd16);
    check("t3_full",  32'(out_full),  32'd1);
    check("t3_head",  32'(out_data),  32'd1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t3_last", 32'(out_data), 32'd20);
    step(1'b0, '0, 1'b1, 1'b0);

    // 4: read and write together while empty.
    step(1'b1, 8'd7, 1'b1, 1'b0);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_data",  32'(out_data),  32'd7);
    check("t4_count", 32'(out_count), 32'd1);

    // 5: write stream with sparse reads, then drain.
    do_reset();
    peak = 0;
    for (int i = 0; i < 32; i++) step(1'b1, 8'((i * 3) % 16), (i % 4) == 3, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t5_peak",  32'(peak),      32'd16);
    check("t5_valid", 32'(out_valid), 32'd0);

    // 6: reset mid-operation, then reuse the FIFO.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 40), 1'b0, 1'b0);
    do_reset();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_count", 32'(out_count), 32'd0);
    check("t6_full",  32'(out_full),  32'd0);
    step(1'b1, 8'd9, 1'b0, 1'b0);
    check("t6_data", 32'(out_data), 32'd9);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
